// File: rtl/vga_pkg.sv
// Shared VGA types: output word layout, pipeline flags, default 640x480 timing
// and the colour-bar table used by the optional test pattern.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
        logic       hsync;
        logic       vsync;
    } vga_out_t;

    // Raster flags that travel alongside a pixel read until its data returns
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic fs;
        logic ls;
    } vga_flags_t;

    function automatic rgb444_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 12'hFFF;
            3'd1:    bar_colour = 12'hFF0;
            3'd2:    bar_colour = 12'h0FF;
            3'd3:    bar_colour = 12'h0F0;
            3'd4:    bar_colour = 12'hF0F;
            3'd5:    bar_colour = 12'hF00;
            3'd6:    bar_colour = 12'h00F;
            default: bar_colour = 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running position counter with wrap, active-region
// and sync-pulse decodes. Instantiated once for h and once for v.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         in_active,
    output logic         in_sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

    assign wrap      = (count == LAST);
    assign in_active = (count < ACT_END);
    assign in_sync   = (count >= SYNC_LO) && (count < SYNC_HI);

endmodule

// File: rtl/vga_scanout.sv
// VGA raster generator: issues framebuffer reads and emits registered RGB444 + syncs.
// Optional colour-bar test pattern is built only when VGA_TEST_PATTERN_EN is defined.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RD_LAT   = 1,
    parameter int ADDR_W   = 19
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              test_mode,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [11:0]       pix_data,
    output logic              frame_start,
    output logic              line_start,
    output logic [13:0]       vgaData
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_wrap, h_active, h_sync;
    logic           v_active, v_sync, v_wrap_unused;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(H_W)
    ) u_h_axis (
        .clk(vga_clk), .reset(reset), .en(1'b1),
        .count(h_cnt), .wrap(h_wrap), .in_active(h_active), .in_sync(h_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(V_W)
    ) u_v_axis (
        .clk(vga_clk), .reset(reset), .en(h_wrap),
        .count(v_cnt), .wrap(v_wrap_unused), .in_active(v_active), .in_sync(v_sync)
    );

    logic              active, origin, line_head;
    logic [ADDR_W-1:0] cur_addr;
    vga_flags_t        st_reg;
    logic [ADDR_W-1:0] addr_reg, next_addr_reg;

    assign active    = h_active && v_active;
    assign origin    = (h_cnt == '0) && (v_cnt == '0);
    assign line_head = (h_cnt == '0);
    assign cur_addr  = origin ? '0 : next_addr_reg;

    // Stage 0: read strobe and address leave the block registered
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            st_reg        <= '0;
            addr_reg      <= '0;
            next_addr_reg <= '0;
        end else begin
            st_reg <= '{active: active, hs: h_sync, vs: v_sync,
                        fs: active && origin, ls: active && line_head};
            if (active) begin
                addr_reg      <= cur_addr;
                next_addr_reg <= cur_addr + ADDR_W'(1);
            end
        end
    end

    assign pix_rd   = st_reg.active;
    assign pix_addr = addr_reg;

    // Flags wait RD_LAT cycles so they meet the returning pixel data
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            vga_flags_t flags_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge vga_clk) begin
                    if (reset) flags_reg <= '0;
                    else       flags_reg <= st_reg;
                end
            end else begin : g_body
                always_ff @(posedge vga_clk) begin
                    if (reset) flags_reg <= '0;
                    else       flags_reg <= g_pipe[gi-1].flags_reg;
                end
            end
        end
    endgenerate

    vga_flags_t tail_flags;
    rgb444_t    src_rgb;
    assign tail_flags = g_pipe[RD_LAT-1].flags_reg;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic        test_mode_reg, pat_sel;
    logic [2:0]  bar_idx;
    logic [12:0] pat_st_reg;

    // Mode is latched only at the frame origin so a frame never tears
    assign pat_sel = origin ? test_mode : test_mode_reg;
    assign bar_idx = 3'(h_cnt / H_W'(BAR_W));

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            test_mode_reg <= 1'b0;
            pat_st_reg    <= '0;
        end else begin
            if (origin) test_mode_reg <= test_mode;
            pat_st_reg <= {pat_sel, bar_colour(bar_idx)};
        end
    end

    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pat
            logic [12:0] pat_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge vga_clk) begin
                    if (reset) pat_reg <= '0;
                    else       pat_reg <= pat_st_reg;
                end
            end else begin : g_body
                always_ff @(posedge vga_clk) begin
                    if (reset) pat_reg <= '0;
                    else       pat_reg <= g_pat[gi-1].pat_reg;
                end
            end
        end
    endgenerate

    logic [12:0] tail_pat;
    assign tail_pat = g_pat[RD_LAT-1].pat_reg;
    assign src_rgb  = tail_pat[12] ? tail_pat[11:0] : pix_data;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign src_rgb          = pix_data;
`endif

    vga_out_t out_reg;
    logic     fs_reg, ls_reg;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            out_reg <= '{red: 4'h0, green: 4'h0, blue: 4'h0,
                         hsync: ~HS_POL, vsync: ~VS_POL};
            fs_reg  <= 1'b0;
            ls_reg  <= 1'b0;
        end else begin
            {out_reg.red, out_reg.green, out_reg.blue} <= tail_flags.active ? src_rgb : 12'h000;
            out_reg.hsync <= tail_flags.hs ? HS_POL : ~HS_POL;
            out_reg.vsync <= tail_flags.vs ? VS_POL : ~VS_POL;
            fs_reg        <= tail_flags.fs;
            ls_reg        <= tail_flags.ls;
        end
    end

    assign vgaData     = out_reg;
    assign frame_start = fs_reg;
    assign line_start  = ls_reg;

endmodule
